// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the sign-magnitude ALU: op-select
//                encodings, default magnitude width and derived widths.
//                Optional build macro (used by sign_mag_alu):
//                ALU_NEG_ZERO_NORM_EN - force sign of zero-magnitude operands
//                to 0 before the operation.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Op-select encodings for the S input
    localparam logic [1:0] SEL_MUL = 2'b00;
    localparam logic [1:0] SEL_MOD = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SUB = 2'b11;

    // Default operand magnitude width
    localparam int DEF_MAG_W = 2;

    // Derived widths for the default configuration
    localparam int DEF_OP_W  = DEF_MAG_W + 1;      // sign + magnitude
    localparam int DEF_ANS_W = 2 * DEF_MAG_W + 1;  // sign + product magnitude

    // Answer width for an arbitrary magnitude width
    function automatic int ans_width(input int mag_w);
        return 2 * mag_w + 1;
    endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/sm_addsub.sv
// ============================================================================
//  Module      : sm_addsub
//  Description : Combinational sign-magnitude adder/subtractor. Converts both
//                operands to two's complement in MAG_W+2 bits (wide enough
//                that no overflow can occur), adds, then converts the sum
//                back to sign-magnitude. A zero sum always has sign 0.
//  Ports       : a_sign, a_mag   - operand A (sign, magnitude)
//                b_sign, b_mag   - operand B (sign, magnitude)
//                sub             - 1: compute A-B, 0: compute A+B
//                sign            - result sign (1 = negative)
//                mag             - result magnitude, MAG_W+2 bits
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_addsub
    import alu_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W
) (
    input  logic             a_sign,
    input  logic [MAG_W-1:0] a_mag,
    input  logic             b_sign,
    input  logic [MAG_W-1:0] b_mag,
    input  logic             sub,
    output logic             sign,
    output logic [MAG_W+1:0] mag
);

    localparam int SUM_W = MAG_W + 2;

    logic [SUM_W-1:0] w_a_ext;
    logic [SUM_W-1:0] w_b_ext;
    logic [SUM_W-1:0] w_a_tc;
    logic [SUM_W-1:0] w_b_tc;
    logic [SUM_W-1:0] w_sum;
    logic             w_b_neg;

    assign w_a_ext = {2'b00, a_mag};
    assign w_b_ext = {2'b00, b_mag};

    // Subtraction is addition of B with its effective sign flipped
    assign w_b_neg = b_sign ^ sub;

    assign w_a_tc = a_sign  ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_tc = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;

    assign w_sum  = w_a_tc + w_b_tc;

    // MSB of the sum is the sign; a zero sum has MSB 0, so -0 never appears
    assign sign = w_sum[SUM_W-1];
    assign mag  = w_sum[SUM_W-1] ? (~w_sum + 1'b1) : w_sum;

endmodule : sm_addsub

`default_nettype wire

// File: rtl/sign_mag_alu.sv
// ============================================================================
//  Module      : sign_mag_alu
//  Description : Registered 4-function ALU on sign-magnitude operands
//                (MUL, MOD, ADD, SUB) with zero (Z) and divide-by-zero (DZ)
//                flags. One-cycle latency, one new operation every cycle.
//                Optional build macro:
//                ALU_NEG_ZERO_NORM_EN - an operand with magnitude 0 has its
//                sign forced to 0 before the operation (affects MOD with -0).
//  Ports       : clk     - rising-edge clock
//                rst_n   - asynchronous active-low reset
//                A, B    - operands, [MAG_W]=sign, [MAG_W-1:0]=magnitude
//                S       - op select: 00 MUL, 01 MOD, 10 ADD, 11 SUB
//                answer  - result, [2*MAG_W]=sign, [2*MAG_W-1:0]=magnitude
//                DZ      - divide-by-zero flag
//                Z       - zero-result flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_mag_alu
    import alu_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MAG_W:0]     A,
    input  logic [MAG_W:0]     B,
    input  logic [1:0]         S,
    output logic [2*MAG_W:0]   answer,
    output logic               DZ,
    output logic               Z
);

    localparam int PROD_W = 2 * MAG_W;

    // ------------------------------------------------------------------
    // Operand split and optional negative-zero normalisation
    // ------------------------------------------------------------------
    logic [MAG_W-1:0] w_am;
    logic [MAG_W-1:0] w_bm;
    logic             w_as;
    logic             w_bs;

    assign w_am = A[MAG_W-1:0];
    assign w_bm = B[MAG_W-1:0];

`ifdef ALU_NEG_ZERO_NORM_EN
    assign w_as = A[MAG_W] & (|w_am);
    assign w_bs = B[MAG_W] & (|w_bm);
`else
    assign w_as = A[MAG_W];
    assign w_bs = B[MAG_W];
`endif

    // ------------------------------------------------------------------
    // Multiply
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] w_prod;
    logic              w_mul_sign;

    assign w_prod     = PROD_W'(w_am) * PROD_W'(w_bm);
    // A zero factor gives a +0 product regardless of operand signs
    assign w_mul_sign = (w_as ^ w_bs) & (|w_am) & (|w_bm);

    // ------------------------------------------------------------------
    // Remainder: divisor replaced by 1 when zero so the operator never
    // sees a zero divisor; that result is discarded via the DZ path.
    // ------------------------------------------------------------------
    logic             w_b_zero;
    logic [MAG_W-1:0] w_bm_safe;
    logic [MAG_W-1:0] w_rem;

    assign w_b_zero  = ~(|w_bm);
    assign w_bm_safe = w_b_zero ? MAG_W'(1) : w_bm;
    assign w_rem     = w_am % w_bm_safe;

    // ------------------------------------------------------------------
    // Add / subtract
    // ------------------------------------------------------------------
    logic             w_as_sign;
    logic [MAG_W+1:0] w_as_mag;

    sm_addsub #(
        .MAG_W (MAG_W)
    ) u_addsub (
        .a_sign (w_as),
        .a_mag  (w_am),
        .b_sign (w_bs),
        .b_mag  (w_bm),
        .sub    (S[0]),
        .sign   (w_as_sign),
        .mag    (w_as_mag)
    );

    // ------------------------------------------------------------------
    // Result select and flags
    // ------------------------------------------------------------------
    logic              w_next_sign;
    logic [PROD_W-1:0] w_next_mag;
    logic              w_next_dz;
    logic              w_next_z;

    always_comb begin
        w_next_sign = 1'b0;
        w_next_mag  = '0;
        w_next_dz   = 1'b0;
        unique case (S)
            SEL_MUL: begin
                w_next_sign = w_mul_sign;
                w_next_mag  = w_prod;
            end
            SEL_MOD: begin
                // Remainder takes the dividend's sign, even when it is 0
                w_next_sign = w_as;
                w_next_dz   = w_b_zero;
                w_next_mag  = w_b_zero ? '0 : PROD_W'(w_rem);
            end
            default: begin  // SEL_ADD, SEL_SUB
                w_next_sign = w_as_sign;
                w_next_mag  = PROD_W'(w_as_mag);
            end
        endcase
        // Z tracks magnitude only; a signed zero still counts as zero
        w_next_z = ~(|w_next_mag);
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [2*MAG_W:0] r_answer;
    logic             r_dz;
    logic             r_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_answer <= '0;
            r_dz     <= 1'b0;
            r_z      <= 1'b1;
        end else begin
            r_answer <= {w_next_sign, w_next_mag};
            r_dz     <= w_next_dz;
            r_z      <= w_next_z;
        end
    end

    assign answer = r_answer;
    assign DZ     = r_dz;
    assign Z      = r_z;

endmodule : sign_mag_alu

`default_nettype wire

// File: tb/tb_sign_mag_alu.sv
// ============================================================================
//  Module      : tb_sign_mag_alu
//  Description : Self-checking bench for sign_mag_alu (MAG_W = 2): reset
//                behaviour, directed vectors for each op, negative-zero
//                operands and a full sweep of S x A x B.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sign_mag_alu;

    localparam int MW = 2;

    logic          clk;
    logic          rst_n;
    logic [MW:0]   a;
    logic [MW:0]   b;
    logic [1:0]    s;
    logic [2*MW:0] answer;
    logic          dz;
    logic          z;

    int tests;
    int fails;

    sign_mag_alu #(
        .MAG_W (MW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .S      (s),
        .answer (answer),
        .DZ     (dz),
        .Z      (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all three outputs against expected values as one vector
    task automatic check(input string tag, input logic [4:0] exp_ans,
                         input logic exp_dz, input logic exp_z);
        logic [6:0] obs;
        logic [6:0] expv;
        obs  = {answer, dz, z};
        expv = {exp_ans, exp_dz, exp_z};
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: answer/DZ/Z observed=%b/%b/%b expected=%b/%b/%b",
                   tag, answer, dz, z, exp_ans, exp_dz, exp_z);
        end
    endtask

    // Drive one op away from the edge, then sample 1 time unit after it
    task automatic apply(input logic [1:0] sel, input logic [2:0] av,
                         input logic [2:0] bv);
        @(negedge clk);
        s = sel;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
    endtask

    // Reference model written directly from the arithmetic rules
    task automatic model(input logic [1:0] sel, input logic [2:0] av,
                         input logic [2:0] bv, output logic [4:0] ans,
                         output logic mdz, output logic mz);
        int am, bm, va, vb, r, mag;
        bit as, bs, sg;
        am  = int'(av[1:0]);
        bm  = int'(bv[1:0]);
        as  = av[2];
        bs  = bv[2];
`ifdef ALU_NEG_ZERO_NORM_EN
        if (am == 0) as = 1'b0;
        if (bm == 0) bs = 1'b0;
`endif
        mdz = 1'b0;
        sg  = 1'b0;
        mag = 0;
        case (sel)
            2'b00: begin
                mag = am * bm;
                sg  = (am != 0 && bm != 0) ? (as ^ bs) : 1'b0;
            end
            2'b01: begin
                sg = as;
                if (bm == 0) begin
                    mag = 0;
                    mdz = 1'b1;
                end else begin
                    mag = am % bm;
                end
            end
            default: begin
                va = as ? -am : am;
                vb = bs ? -bm : bm;
                if (sel == 2'b11) vb = -vb;
                r   = va + vb;
                sg  = (r < 0);
                mag = (r < 0) ? -r : r;
            end
        endcase
        ans = {sg, 4'(mag)};
        mz  = (mag == 0);
    endtask

    initial begin
        logic [4:0] e_ans;
        logic       e_dz;
        logic       e_z;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        s     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 5'b00000, 1'b0, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;

        // Establish a non-reset output, then reset asynchronously mid-cycle
        apply(2'b00, 3'b011, 3'b111);
        check("mul_p3_m3", 5'b11001, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 5'b00000, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_hold", 5'b00000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("first_edge_after_reset", 5'b11001, 1'b0, 1'b0);

        // MUL
        apply(2'b00, 3'b110, 3'b000);
        check("mul_m2_zero", 5'b00000, 1'b0, 1'b1);
        apply(2'b00, 3'b111, 3'b111);
        check("mul_m3_m3", 5'b01001, 1'b0, 1'b0);

        // Remainder operation
        apply(2'b01, 3'b111, 3'b010);
        check("mod_m3_p2", 5'b10001, 1'b0, 1'b0);
        apply(2'b01, 3'b011, 3'b000);
        check("mod_div_zero", 5'b00000, 1'b1, 1'b1);
        apply(2'b01, 3'b010, 3'b001);
        check("mod_exact", 5'b00000, 1'b0, 1'b1);
        apply(2'b01, 3'b110, 3'b001);
        check("mod_neg_exact", 5'b10000, 1'b0, 1'b1);

        // ADD
        apply(2'b10, 3'b011, 3'b011);
        check("add_p3_p3", 5'b00110, 1'b0, 1'b0);
        apply(2'b10, 3'b001, 3'b110);
        check("add_p1_m2", 5'b10001, 1'b0, 1'b0);
        apply(2'b10, 3'b010, 3'b110);
        check("add_cancel", 5'b00000, 1'b0, 1'b1);
        apply(2'b10, 3'b111, 3'b111);
        check("add_m3_m3", 5'b10110, 1'b0, 1'b0);

        // SUB
        apply(2'b11, 3'b101, 3'b011);
        check("sub_m1_p3", 5'b10100, 1'b0, 1'b0);
        apply(2'b11, 3'b111, 3'b111);
        check("sub_equal", 5'b00000, 1'b0, 1'b1);
        apply(2'b11, 3'b011, 3'b111);
        check("sub_p3_m3", 5'b00110, 1'b0, 1'b0);

        // Negative-zero operands
        apply(2'b00, 3'b100, 3'b111);
        check("mul_negzero", 5'b00000, 1'b0, 1'b1);
        apply(2'b10, 3'b100, 3'b100);
        check("add_negzero", 5'b00000, 1'b0, 1'b1);
        apply(2'b01, 3'b100, 3'b011);
`ifdef ALU_NEG_ZERO_NORM_EN
        check("mod_negzero", 5'b00000, 1'b0, 1'b1);
`else
        check("mod_negzero", 5'b10000, 1'b0, 1'b1);
`endif

        // Full sweep, one op per cycle
        for (int si = 0; si < 4; si++) begin
            for (int ai = 0; ai < 8; ai++) begin
                for (int bi = 0; bi < 8; bi++) begin
                    apply(2'(si), 3'(ai), 3'(bi));
                    model(2'(si), 3'(ai), 3'(bi), e_ans, e_dz, e_z);
                    check($sformatf("sweep_s%0d_a%0d_b%0d", si, ai, bi),
                          e_ans, e_dz, e_z);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_sign_mag_alu

`default_nettype wire
